// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle controller for the RV32M multiply/divide path in the execute
//   stage. One M-extension operation is accepted at a time. Multiplies take a
//   fixed MUL_LATENCY cycles. Divides and remainders run a 32-iteration
//   restoring shift-subtract loop. Divide-by-zero and signed overflow
//   complete on the cycle after acceptance. A flush cancels any in-flight
//   operation without producing a result.
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         asynchronous active-low reset
//   start       execute stage holds an M-ext instruction (level)
//   op          funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU,
//               4 DIV, 5 DIVU, 6 REM, 7 REMU
//   rs1, rs2    bypassed operands (dividend/multiplicand, divisor/multiplier)
//   flush       cancel the in-flight operation (branch mispredict)
//   busy        combinational stall request to the pipeline controller
//   resultValid result is available this cycle (one-cycle pulse)
//   result      registered result, held until the next completion

module muldiv_sequencer #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            resultValid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;

  localparam logic [5:0] MulLast = 6'(MUL_LATENCY - 1);
  localparam logic [5:0] DivLast = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  stateT             state;
  logic [5:0]        cnt;
  logic [2:0]        opQ;
  logic [XLEN-1:0]   opA;      // dividend magnitude; quotient bits shift in from the right
  logic [XLEN-1:0]   opB;      // divisor magnitude
  logic [XLEN-1:0]   remQ;     // partial remainder
  logic [2*XLEN-1:0] product;
  logic              negQuo;
  logic              negRem;

  // Decode of the incoming operation (used only in the accept cycle)
  logic              signA;
  logic              signB;
  logic              divSigned;
  logic              divByZero;
  logic              divOverflow;
  logic [XLEN:0]     extA;
  logic [XLEN:0]     extB;
  logic [2*XLEN-1:0] mulProduct;
  logic [XLEN-1:0]   absA;
  logic [XLEN-1:0]   absB;
  logic [XLEN-1:0]   specialResult;

  // One restoring-divide iteration
  logic [XLEN:0]     remShift;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   remNext;
  logic [XLEN-1:0]   quoNext;
  logic [XLEN-1:0]   quoFinal;
  logic [XLEN-1:0]   remFinal;

  // NOTE: every always_comb output is given a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    signA         = 1'b0;
    signB         = 1'b0;
    divSigned     = 1'b0;
    extA          = '0;
    extB          = '0;
    mulProduct    = '0;
    absA          = rs1;
    absB          = rs2;
    divByZero     = 1'b0;
    divOverflow   = 1'b0;
    specialResult = '0;

    // MUL/MULH/MULHSU sign-extend rs1; MUL/MULH sign-extend rs2.
    signA      = !op[2] && (op[1:0] != 2'd3);
    signB      = !op[2] && !op[1];
    extA       = {signA & rs1[XLEN-1], rs1};
    extB       = {signB & rs2[XLEN-1], rs2};
    mulProduct = (2*XLEN)'($signed(extA)) * (2*XLEN)'($signed(extB));

    // DIV and REM are the signed divide ops (funct3 bit 0 clear).
    divSigned   = op[2] && !op[0];
    absA        = (divSigned && rs1[XLEN-1]) ? -rs1 : rs1;
    absB        = (divSigned && rs2[XLEN-1]) ? -rs2 : rs2;
    divByZero   = (rs2 == '0);
    divOverflow = divSigned && (rs1 == MinInt) && (rs2 == '1);

    if (op[1]) specialResult = divByZero ? rs1 : '0;       // REM / REMU
    else       specialResult = divByZero ? '1  : MinInt;   // DIV / DIVU
  end

  always_comb begin
    remShift = {remQ, opA[XLEN-1]};
    diff     = remShift - {1'b0, opB};
    // A borrow out of the trial subtraction means the divisor did not fit.
    remNext  = diff[XLEN] ? remShift[XLEN-1:0] : diff[XLEN-1:0];
    quoNext  = {opA[XLEN-2:0], !diff[XLEN]};
    quoFinal = negQuo ? -quoNext : quoNext;
    remFinal = negRem ? -remNext : remNext;
  end

  assign busy = ((state == IDLE) && start && !flush) || (state == MUL) || (state == DIV);

  // NOTE: every register, datapath included, is cleared by reset so the block
  // starts from a known state and result reads 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      opQ         <= '0;
      opA         <= '0;
      opB         <= '0;
      remQ        <= '0;
      product     <= '0;
      negQuo      <= 1'b0;
      negRem      <= 1'b0;
      result      <= '0;
      resultValid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // sees the values from before this clock edge.
      resultValid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            opQ <= op;
            cnt <= '0;
            if (!op[2]) begin
              product <= mulProduct;
              state   <= MUL;
            end else if (divByZero || divOverflow) begin
              result      <= specialResult;
              resultValid <= 1'b1;
              state       <= DONE;
            end else begin
              opA    <= absA;
              opB    <= absB;
              remQ   <= '0;
              negQuo <= divSigned && (rs1[XLEN-1] ^ rs2[XLEN-1]);
              negRem <= divSigned && rs1[XLEN-1];
              state  <= DIV;
            end
          end
        end

        MUL: begin
          if (flush) begin
            state <= IDLE;
          end else if (cnt == MulLast) begin
            result      <= (opQ == 3'd0) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
            resultValid <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end

        DIV: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            opA  <= quoNext;
            remQ <= remNext;
            cnt  <= cnt + 6'd1;
            if (cnt == DivLast) begin
              result      <= opQ[1] ? remFinal : quoFinal;
              resultValid <= 1'b1;
              state       <= DONE;
            end
          end
        end

        // start is still the same instruction here and is ignored.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Scoreboard bench for muldiv_sequencer. The driver issues operations and
//   pushes the reference result and completion latency into a queue; an
//   independent monitor pops an entry whenever resultValid is seen.

module tb_muldiv_sequencer;

  localparam int MUL_LATENCY = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        resultValid;
  logic [31:0] result;

  muldiv_sequencer #(.XLEN(32), .MUL_LATENCY(MUL_LATENCY)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy), .resultValid(resultValid), .result(result)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
    string       name;
  } expT;

  expT sb[$];
  int  tests    = 0;
  int  fails    = 0;
  int  cycleCnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: RV32M semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint p;
    logic [63:0] bits;
    case (f)
      3'd0: p = sa * sb;
      3'd1: p = sa * sb;
      3'd2: p = sa * ub;
      3'd3: p = ua * ub;
      3'd4: p = (b == 0) ? -1 : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? sa : sa / sb);
      3'd5: p = (b == 0) ? -1 : ua / ub;
      3'd6: p = (b == 0) ? sa : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 0 : sa % sb);
      default: p = (b == 0) ? ua : ua % ub;
    endcase
    bits = p;
    if (f == 3'd1 || f == 3'd2 || f == 3'd3) return bits[63:32];
    return bits[31:0];
  endfunction

  function automatic int refLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f < 3'd4) return MUL_LATENCY + 1;
    if (b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one operation and hold start until its DONE cycle, checking busy
  // against the expected latency on every cycle.
  task automatic doOp(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    expT e;
    bit  got;
    int  lat;
    @(negedge clk);
    start = 1'b1;
    op    = f;
    rs1   = a;
    rs2   = b;
    lat   = refLatency(f, a, b);
    e.res = refModel(f, a, b);
    e.lat = lat;
    e.acc = cycleCnt;
    e.name = name;
    sb.push_back(e);
    #1 check({name, "_busy_accept"}, busy, 1);
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      #1;
      check({name, "_busy"}, busy, (k < lat) ? 1 : 0);
      if (resultValid) got = 1'b1;
    end
    check({name, "_completed"}, got, 1);
  endtask

  // Monitor: compare every presented result against the scoreboard.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (rst && resultValid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", resultValid, 0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_result"}, result, e.res);
          check({e.name, "_latency"}, cycleCnt - e.acc, e.lat);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish (tests=%0d)", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f;
    start = 1'b0;
    op    = '0;
    rs1   = '0;
    rs2   = '0;
    flush = 1'b0;
    rst   = 1'b0;

    #1;
    check("reset_busy", busy, 0);
    check("reset_valid", resultValid, 0);
    check("reset_result", result, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases
    doOp("mul",     3'd0, 32'hFFFF_FFFF, 32'd2);
    doOp("mulh",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    doOp("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    doOp("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    doOp("div",     3'd4, 32'hFFFF_FFF9, 32'd2);
    doOp("rem",     3'd6, 32'hFFFF_FFF9, 32'd2);
    doOp("divu",    3'd5, 32'h8000_0000, 32'd3);
    doOp("divu_z",  3'd5, 32'd5, 32'd0);
    doOp("rem_z",   3'd6, 32'd5, 32'd0);
    doOp("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    doOp("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    doOp("remu",    3'd7, 32'd100, 32'd7);

    // flush at cycle 10 of a DIV, then a MUL issued at cycle 12
    @(negedge clk);
    start = 1'b1;
    op    = 3'd4;
    rs1   = 32'd1000;
    rs2   = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1 check("flush_idle_busy", busy, 0);
    doOp("mul_after_flush", 3'd0, 32'd1234, 32'd5678);

    // flush in IDLE blocks acceptance
    @(negedge clk);
    start = 1'b1;
    op    = 3'd0;
    rs1   = 32'd3;
    rs2   = 32'd4;
    flush = 1'b1;
    #1 check("idle_flush_busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    #1 check("idle_flush_not_accepted", busy, 0);
    repeat (4) @(negedge clk);

    // reset pulsed mid-DIV
    @(negedge clk);
    start = 1'b1;
    op    = 3'd5;
    rs1   = 32'd100;
    rs2   = 32'd7;
    repeat (6) @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_valid", resultValid, 0);
    check("midreset_result", result, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Randomized operations, issued back to back
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      doOp($sformatf("rand%0d_op%0d", i, f), f, pickOperand(), pickOperand());
    end

    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller for the RV32M multiply/divide path in the execute stage. It accepts one M-extension operation at a time, sequences a fixed-latency multiply or a 32-iteration restoring divide, and drives the execute stage's mul/div busy indication so the controller stalls the pipeline. It handles the RISC-V divide-by-zero and signed-overflow cases, and honours pipeline flushes from branch misprediction.

## Interface
Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- MUL_LATENCY, 2, cycles spent in MUL state (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  execute stage holds an M-ext instruction; level, held until consumed
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1  in  XLEN  bypassed operand 1 (dividend / multiplicand)
- rs2  in  XLEN  bypassed operand 2 (divisor / multiplier)
- flush  in  1  cancel any in-flight operation (branch mispredict)
- busy  out  1  combinational stall request to controller (maps to isMulDivUnitBusy)
- resultValid  out  1  result available this cycle
- result  out  XLEN  registered result

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: if start && !flush, latch op, rs1, rs2 and leave IDLE. MUL ops → MUL with cycle counter = 0. DIV/REM ops → DIV with iteration counter = 0, or directly → DONE for the special cases below.
- MUL: 64-bit product of 33-bit extended operands.
  - rs1 is sign-extended for MUL, MULH and MULHSU; rs2 is sign-extended for MUL and MULH; every other case zero-extends.
  - MUL returns product[31:0]; the other multiply ops return product[63:32].
  - The product may be computed at latch time; the counter enforces MUL_LATENCY cycles before DONE.
- DIV: restoring shift-subtract on magnitudes, one quotient bit per cycle, 32 iterations (counter 0..31).
  - Signed ops (DIV, REM) take |rs1| and |rs2|.
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned ops (DIVU, REMU) use operands directly.
- Special cases, decided in IDLE, go straight to DONE:
  - rs2 == 0: quotient = all ones, remainder = rs1.
  - Signed DIV/REM with rs1 == 0x80000000 and rs2 == 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- DONE: result register is loaded on entry; resultValid = 1 for exactly one cycle; next state is IDLE. start seen in DONE is ignored, because it is the same instruction still in execute.
- busy = (IDLE && start && !flush) || MUL || DIV. busy is 0 in DONE, so the pipeline advances in the same cycle it samples result.
- flush:
  - In MUL, DIV or DONE: next state IDLE, no resultValid afterward.
  - In IDLE: start is ignored and busy = 0.
  - flush has priority over start and over completion.

## Timing
- Reset (rst low, async): state IDLE, counters 0, latched operands 0, result 0, resultValid 0. busy is 0 while in IDLE with start low.
- Accept cycle is cycle 0.
- Multiply: MUL during cycles 1..MUL_LATENCY; DONE / resultValid at cycle MUL_LATENCY+1 (cycle 3 by default).
- Divide: DIV during cycles 1..32; DONE at cycle 33.
- Special divide cases: DONE at cycle 1.
- Back-to-back: a start in the cycle after DONE is accepted normally, with no bubble beyond the DONE cycle.
- result holds its value until the next DONE; it is only meaningful while resultValid is 1.
- Reset asserted mid-operation returns the block to IDLE immediately, with no resultValid.

## Test plan
- MUL: rs1 = 0xFFFFFFFF, rs2 = 2, default latency -> busy high cycles 0–2; resultValid at cycle 3; result 0xFFFFFFFE.
- MULH / MULHSU / MULHU: rs1 = 0xFFFFFFFF, rs2 = 0xFFFFFFFF -> results 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE.
- DIV: rs1 = -7, rs2 = 2 -> result 0xFFFFFFFD at cycle 33. REM with the same operands -> 0xFFFFFFFF. DIVU: 0x80000000 / 3 -> 0x2AAAAAAA.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF at cycle 1. REM 5/0 -> 5. Overflow: DIV 0x80000000 / -1 -> 0x80000000 at cycle 1.
- flush at cycle 10 of a DIV -> IDLE at cycle 11, no resultValid. A new MUL started at cycle 12 -> correct result at cycle 15.
- rst pulsed low mid-DIV -> all outputs 0 immediately. start held through DONE -> exactly one resultValid, no re-issue.
